// File: rtl/prog_tick_timer_pkg.sv
// rtl/prog_tick_timer_pkg.sv - shared state encoding and mode constants for prog_tick_timer
package prog_tick_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_tick_timer_tick_counter.sv
// rtl/prog_tick_timer_tick_counter.sv - period counter with load-to-zero, increment and terminal detect
module tick_counter #(
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic [CNT_W-1:0] count_o,
   output logic             at_term_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // limit_i is never zero, so limit_i-1 cannot wrap
   assign at_term_o = (count_q == limit_i - CNT_W'(1));
   assign count_o   = count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = at_term_o ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/prog_tick_timer.sv
// rtl/prog_tick_timer.sv - programmable tick timer: one-shot/periodic, pause, sticky done/overrun
module prog_tick_timer
   import prog_tick_timer_pkg::*;
#(
   parameter int CNT_W         = 7,
   parameter int DEFAULT_LIMIT = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear,
   input  logic             enable,
   input  logic             tick_in,
   input  logic [CNT_W-1:0] limit,
   input  logic             use_default,
   input  logic             mode,
   input  logic             done_ack,
   output logic             tick_out,
   output logic             done,
   output logic             overrun,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             cfg_err
);

   localparam logic [CNT_W-1:0] DEF_LIMIT = CNT_W'(DEFAULT_LIMIT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic             mode_q, mode_d;
   logic             tick_out_q, tick_out_d;
   logic             done_q, done_d;
   logic             overrun_q, overrun_d;
   logic             cfg_err_q, cfg_err_d;
   logic             cnt_load, cnt_inc, at_term;
   logic [CNT_W-1:0] eff_limit;
   logic             eff_zero;

   assign eff_limit = use_default ? DEF_LIMIT : limit;
   assign eff_zero  = (eff_limit == '0);

   tick_counter #(.CNT_W(CNT_W)) u_counter (
      .clk       (clk),
      .rst       (rst),
      .load_i    (cnt_load),
      .inc_i     (cnt_inc),
      .limit_i   (limit_q),
      .count_o   (count),
      .at_term_o (at_term)
   );

   always_comb begin
      state_d    = state_q;
      limit_d    = limit_q;
      mode_d     = mode_q;
      tick_out_d = 1'b0;
      done_d     = done_q & ~done_ack;
      overrun_d  = overrun_q;
      cfg_err_d  = 1'b0;
      cnt_load   = 1'b0;
      cnt_inc    = 1'b0;
      if (clear) begin
         state_d   = ST_IDLE;
         done_d    = 1'b0;
         overrun_d = 1'b0;
         cnt_load  = 1'b1;
      end else if (start) begin
         // a rejected start consumes the cycle: no ticks are counted alongside it
         if (eff_zero) begin
            cfg_err_d = 1'b1;
         end else begin
            state_d   = ST_RUN;
            limit_d   = eff_limit;
            mode_d    = mode;
            overrun_d = 1'b0;
            cnt_load  = 1'b1;
         end
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (!enable) begin
                  state_d = ST_HOLD;
               end else if (tick_in) begin
                  cnt_inc = 1'b1;
                  if (at_term) begin
                     tick_out_d = 1'b1;
                     done_d     = 1'b1;
                     if (done_q && !done_ack) overrun_d = 1'b1;
                     if (mode_q == MODE_ONESHOT) begin
                        state_d = ST_DONE;
                     end else if (eff_zero) begin
                        cfg_err_d = 1'b1;
                     end else begin
                        limit_d = eff_limit;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (enable) state_d = ST_RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         limit_q    <= DEF_LIMIT;
         mode_q     <= MODE_ONESHOT;
         tick_out_q <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         limit_q    <= limit_d;
         mode_q     <= mode_d;
         tick_out_q <= tick_out_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign tick_out = tick_out_q;
   assign done     = done_q;
   assign overrun  = overrun_q;
   assign cfg_err  = cfg_err_q;
   assign busy     = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_prog_tick_timer.sv
// tb/tb_prog_tick_timer.sv - directed and randomized checks of prog_tick_timer against a behavioural model
module tb_prog_tick_timer;

   localparam int CNT_W = 7;
   localparam int DEF   = 100;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0, clear = 1'b0, enable = 1'b0, tick_in = 1'b0;
   logic [CNT_W-1:0] limit = '0;
   logic             use_default = 1'b0, mode = 1'b0, done_ack = 1'b0;
   logic             tick_out, done, overrun, busy, cfg_err;
   logic [CNT_W-1:0] count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   prog_tick_timer #(.CNT_W(CNT_W), .DEFAULT_LIMIT(DEF)) dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .enable(enable),
      .tick_in(tick_in), .limit(limit), .use_default(use_default), .mode(mode),
      .done_ack(done_ack), .tick_out(tick_out), .done(done), .overrun(overrun),
      .busy(busy), .count(count), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   // behavioural model: running/paused flags, a tick tally and the period length
   bit m_run = 0, m_pause = 0, m_per = 0;
   int m_cnt = 0, m_lim = DEF;
   bit e_tick = 0, e_done = 0, e_ovr = 0, e_cfg = 0;

   always @(posedge clk) begin
      int  eff;
      bit  wrap;
      eff  = use_default ? DEF : int'(limit);
      wrap = 0;
      if (!rst) begin
         m_run = 0; m_pause = 0; m_per = 0; m_cnt = 0; m_lim = DEF;
         e_tick = 0; e_done = 0; e_ovr = 0; e_cfg = 0;
      end else begin
         e_tick = 0;
         e_cfg  = 0;
         if (clear) begin
            m_run = 0; m_pause = 0; m_cnt = 0; e_done = 0; e_ovr = 0;
         end else if (start) begin
            if (eff == 0) e_cfg = 1;
            else begin
               m_run = 1; m_pause = 0; m_cnt = 0; m_lim = eff; m_per = mode; e_ovr = 0;
            end
            if (done_ack) e_done = 0;
         end else begin
            if (m_run && !m_pause) begin
               if (!enable) m_pause = 1;
               else if (tick_in) begin
                  m_cnt = m_cnt + 1;
                  if (m_cnt == m_lim) wrap = 1;
               end
            end else if (m_run && m_pause && enable) begin
               m_pause = 0;
            end
            if (wrap) begin
               m_cnt  = 0;
               e_tick = 1;
               if (e_done && !done_ack) e_ovr = 1;
               e_done = 1;
               if (!m_per) m_run = 0;
               else if (eff != 0) m_lim = eff;
               else e_cfg = 1;
            end else if (done_ack) begin
               e_done = 0;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",     int'(busy),     int'(m_run));
         chk("count",    int'(count),    m_cnt);
         chk("tick_out", int'(tick_out), int'(e_tick));
         chk("done",     int'(done),     int'(e_done));
         chk("overrun",  int'(overrun),  int'(e_ovr));
         chk("cfg_err",  int'(cfg_err),  int'(e_cfg));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk); tick_in = 1'b1;
      @(negedge clk); tick_in = 1'b0;
   endtask

   task automatic do_start(input int lim, input bit md, input bit ud);
      @(negedge clk);
      start = 1'b1; limit = CNT_W'(lim); mode = md; use_default = ud;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   task automatic do_ack();
      @(negedge clk); done_ack = 1'b1;
      @(negedge clk); done_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      cyc(3);
      chk_en = 1'b1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_tick_out", int'(tick_out), 0);
      @(negedge clk); rst = 1'b1; enable = 1'b1;

      // one-shot, limit 5, ticks 3 clk apart
      do_start(5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 3) chk("os_cnt4", int'(count), 4);
         if (i < 4) cyc(2);
      end
      chk("os_tick_out", int'(tick_out), 1);
      chk("os_done", int'(done), 1);
      chk("os_busy", int'(busy), 0);
      chk("os_count", int'(count), 0);
      cyc(1);
      chk("os_pulse_len", int'(tick_out), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("os_ignored", int'(tick_out), 0);
      end

      // periodic limit 3, 9 ticks, ack after the first period only
      do_clear();
      do_start(3, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i % 3 == 2) chk("per_tick_out", int'(tick_out), 1);
         if (i == 2) begin
            do_ack();
            chk("per_acked", int'(done), 0);
         end
         if (i == 5) chk("per_no_ovr", int'(overrun), 0);
      end
      chk("per_ovr", int'(overrun), 1);
      chk("per_done", int'(done), 1);
      chk("per_busy", int'(busy), 1);

      // periodic limit 4, limit changed to 2 mid-period
      do_clear();
      do_start(4, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 2) limit = CNT_W'(2);
         if (i == 3) chk("chg_mid", int'(tick_out), 0);
         if (i == 4 || i == 6 || i == 8) chk("chg_wrap", int'(tick_out), 1);
         if (i == 5 || i == 7) chk("chg_nowrap", int'(tick_out), 0);
      end

      // pause: 4 ticks, 20 cycles disabled with 5 ticks, then 6 more
      do_clear();
      do_start(10, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      @(negedge clk); enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         cyc(2);
      end
      chk("pause_hold", int'(count), 4);
      chk("pause_model", m_cnt, 4);
      chk("pause_busy", int'(busy), 1);
      @(negedge clk); enable = 1'b1;
      cyc(1);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 4) chk("resume_cnt9", int'(count), 9);
      end
      chk("resume_tick_out", int'(tick_out), 1);

      // zero limit rejected, then default limit
      do_clear();
      do_start(0, 1'b0, 1'b0);
      chk("zero_cfg_err", int'(cfg_err), 1);
      chk("zero_busy", int'(busy), 0);
      cyc(1);
      chk("zero_cfg_pulse", int'(cfg_err), 0);
      do_start(0, 1'b0, 1'b1);
      chk("def_busy", int'(busy), 1);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (i == 98) chk("def_cnt99", int'(count), 99);
      end
      chk("def_tick_out", int'(tick_out), 1);

      // clear coincident with terminal tick
      do_start(3, 1'b0, 1'b0);
      tick(); tick();
      @(negedge clk); clear = 1'b1; tick_in = 1'b1;
      @(negedge clk); clear = 1'b0; tick_in = 1'b0;
      chk("clr_tick_out", int'(tick_out), 0);
      chk("clr_done", int'(done), 0);
      chk("clr_busy", int'(busy), 0);
      cyc(1);
      chk("clr_late_tick", int'(tick_out), 0);

      // reset mid-count
      do_start(8, 1'b1, 1'b0);
      tick(); tick(); tick();
      @(negedge clk); rst = 1'b0; tick_in = 1'b1;
      @(negedge clk); rst = 1'b1; tick_in = 1'b0;
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_count", int'(count), 0);
      chk("rst_mid_tick_out", int'(tick_out), 0);

      // randomized traffic, small limits for frequent wraps
      for (int i = 0; i < 4000; i++) begin
         int r;
         @(negedge clk);
         r           = int'($urandom_range(0, 999));
         rst         = (r >= 3);
         start       = (r >= 3 && r < 40);
         clear       = (r >= 40 && r < 50);
         tick_in     = ($urandom_range(0, 2) == 0);
         enable      = ($urandom_range(0, 9) != 0);
         done_ack    = ($urandom_range(0, 7) == 0);
         limit       = CNT_W'($urandom_range(0, 7));
         use_default = ($urandom_range(0, 19) == 0);
         mode        = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      rst = 1'b1; start = 1'b0; clear = 1'b0; tick_in = 1'b0; done_ack = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
